// File: rtl/simd_isa_pkg.sv
// Shared ISA constants for the SIMD issue path: field positions, widths,
// special opcodes and the issue-controller state encoding.
package simd_isa_pkg;

   localparam int NREG   = 32;
   localparam int REGW   = 5;
   localparam int OPW    = 4;
   localparam int SCNT_W = 16;

   localparam int OP_MSB   = 31;
   localparam int OP_LSB   = 28;
   localparam int SRC1_MSB = 27;
   localparam int SRC1_LSB = 23;
   localparam int SRC2_MSB = 22;
   localparam int SRC2_LSB = 18;
   localparam int DEST_MSB = 17;
   localparam int DEST_LSB = 13;

   localparam logic [OPW-1:0] NOP_OP  = 4'h0;
   localparam logic [OPW-1:0] HALT_OP = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

endpackage

// File: rtl/simd_scoreboard.sv
// Busy-register scoreboard: one pending-write bit per vector register,
// with a set port (issue), a clear port (writeback) and a 3-way hazard lookup.
module simd_scoreboard
   import simd_isa_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_en,
   input  logic [REGW-1:0] set_idx,
   input  logic            clr_en,
   input  logic [REGW-1:0] clr_idx,
   input  logic [REGW-1:0] rd_a,
   input  logic [REGW-1:0] rd_b,
   input  logic [REGW-1:0] rd_c,
   output logic            hazard,
   output logic [NREG-1:0] busy
);

   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;

   assign set_mask = set_en ? (NREG'(1) << set_idx) : '0;
   assign clr_mask = clr_en ? (NREG'(1) << clr_idx) : '0;

   // Set is applied after clear so an issue wins over a same-cycle writeback.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= (busy & ~clr_mask) | set_mask;
   end

   assign hazard = busy[rd_a] | busy[rd_b] | busy[rd_c];

endmodule

// File: rtl/simd_issue_ctrl.sv
// Issue controller: decodes fetched SIMD words, stalls on register hazards,
// hands hazard-free instructions to the execution unit, and drains on HALT.
module simd_issue_ctrl
   import simd_isa_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [31:0]       in_instr,
   output logic              in_ready,
   output logic              iss_valid,
   input  logic              iss_ready,
   output logic [OPW-1:0]    iss_opcode,
   output logic [REGW-1:0]   iss_src1,
   output logic [REGW-1:0]   iss_src2,
   output logic [REGW-1:0]   iss_dest,
   input  logic              wb_valid,
   input  logic [REGW-1:0]   wb_dest,
   input  logic              resume,
   output logic              halted,
   output logic [NREG-1:0]   busy_vec,
   output logic [SCNT_W-1:0] stall_cnt
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; a raised iss_valid holds until iss_ready, fields stay stable.
   state_t          state;
   state_t          state_nx;
   logic            hazard;
   logic            accept;
   logic            fire;
   logic            set_en;
   logic [OPW-1:0]  dec_op;

   assign dec_op    = in_instr[OP_MSB:OP_LSB];
   assign in_ready  = rst_n & (state == ST_IDLE);
   assign iss_valid = (state == ST_ISSUE);
   assign halted    = (state == ST_HALTED);
   assign accept    = in_ready & in_valid;
   assign fire      = iss_valid & iss_ready;
   assign set_en    = fire & (iss_opcode != NOP_OP);

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (in_valid) state_nx = (dec_op == HALT_OP) ? ST_DRAIN : ST_CHECK;
         ST_CHECK:  if (!hazard) state_nx = ST_ISSUE;
         ST_ISSUE:  if (iss_ready) state_nx = ST_IDLE;
         ST_DRAIN:  if (busy_vec == '0) state_nx = ST_HALTED;
         ST_HALTED: if (resume) state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         iss_opcode <= '0;
         iss_src1   <= '0;
         iss_src2   <= '0;
         iss_dest   <= '0;
         stall_cnt  <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            iss_opcode <= dec_op;
            iss_src1   <= in_instr[SRC1_MSB:SRC1_LSB];
            iss_src2   <= in_instr[SRC2_MSB:SRC2_LSB];
            iss_dest   <= in_instr[DEST_MSB:DEST_LSB];
         end
         if (state == ST_CHECK && hazard && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   simd_scoreboard u_sb (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_en  (set_en),
      .set_idx (iss_dest),
      .clr_en  (wb_valid),
      .clr_idx (wb_dest),
      .rd_a    (iss_src1),
      .rd_b    (iss_src2),
      .rd_c    (iss_dest),
      .hazard  (hazard),
      .busy    (busy_vec)
   );

endmodule
